sub_shift_stage: RTL and testbench

SUB_SHIFT_STAGE -- requirements
Module: sub_shift_stage

---
 rtl/sub_shift_stage.sv | 139 +++++++++++++
 tb/tb_sub_shift_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_shift_stage.sv
// AES SubBytes + ShiftRows stage: substitutes COLS_PER_CYCLE state columns per cycle,
// then presents the ShiftRows-permuted state to the MixColumn stage with valid/ready.
module sub_shift_stage #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    localparam logic [1:0] COL_STEP  = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST_BASE = 2'((4 - COLS_PER_CYCLE) % 4);

    // FIPS-197 S-box, entry x at bits [2047-8x -: 8]
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    state_t       state;
    state_t       state_next;
    logic [1:0]   col_cnt;
    logic [127:0] work_q;
    logic [127:0] sub_state;
    logic [127:0] out_state_q;
    logic         last_step;

    // col_cnt is always a multiple of COLS_PER_CYCLE, so the selected columns never wrap
    always_comb begin
        sub_state = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            for (int r = 0; r < 4; r++) begin
                sub_state[127 - 8 * (4 * (int'(col_cnt) + j) + r) -: 8] =
                    sbox(work_q[127 - 8 * (4 * (int'(col_cnt) + j) + r) -: 8]);
            end
        end
    end

    assign last_step = (col_cnt == LAST_BASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_next = SUB;
                SUB:     if (last_step) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Output register is only rewritten by a completed block; flush leaves it intact
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt     <= 2'd0;
            work_q      <= '0;
            out_state_q <= '0;
        end else if (flush) begin
            col_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        col_cnt <= 2'd0;
                    end
                end
                SUB: begin
                    work_q  <= sub_state;
                    col_cnt <= col_cnt + COL_STEP;
                    if (last_step) begin
                        out_state_q <= shift_rows(sub_state);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_state = out_state_q;

endmodule

// File: tb/tb_sub_shift_stage.sv
// Bench for sub_shift_stage: one instance per COLS_PER_CYCLE (1, 2, 4) checked against
// an arithmetic AES model (GF(2^8) inverse + affine map, whole-block ShiftRows).
module tb_sub_shift_stage;

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};
    localparam logic [127:0] ONES_OUT = {16{8'h16}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a       [3];
    logic         flush_a     [3];
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] in_state_a  [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_state_a [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sub_shift_stage #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk       (clk),
            .rst       (rst_a[g]),
            .flush     (flush_a[g]),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_state  (in_state_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g])
        );
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] sbox_tab [256];

    typedef struct {
        int           unit;
        logic [127:0] st;
        logic [127:0] exp;
        int           hold;
        bit           early;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(x));
            end
            sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [7:0]   b [16];
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) b[i] = s[127 - 8 * i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = sbox_tab[b[4 * ((c + r) % 4) + r]];
            end
        end
        return o;
    endfunction

    task automatic check_vec(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input int u, input string name, input logic [127:0] exp);
        check_vec({name, " out_state"}, out_state_a[u], exp);
    endtask

    task automatic applyStimulus(input int u, input logic [127:0] st, input logic [127:0] exp,
                                 input int hold, input bit early, input bit toggle, input string name);
        int lat;
        int w;
        lat = 4 >> u;
        w = 0;
        while (in_ready_a[u] !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check_bit({name, " in_ready before handshake"}, in_ready_a[u], 1'b1);
        in_valid_a[u]  = 1'b1;
        in_state_a[u]  = st;
        out_ready_a[u] = early;
        @(posedge clk); #1;
        in_valid_a[u] = 1'b0;
        for (int e = 0; e <= lat; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            check_bit($sformatf("%s out_valid after edge k+%0d", name, e), out_valid_a[u], e == lat);
            if (toggle && e < lat) begin
                in_state_a[u] = {$urandom, $urandom, $urandom, $urandom};
                in_valid_a[u] = 1'($urandom_range(0, 1));
            end else begin
                in_valid_a[u] = 1'b0;
            end
        end
        checkOutput(u, name, exp);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check_bit($sformatf("%s held out_valid %0d", name, h), out_valid_a[u], 1'b1);
                check_bit($sformatf("%s held in_ready %0d", name, h), in_ready_a[u], 1'b0);
                checkOutput(u, $sformatf("%s held %0d", name, h), exp);
            end
        end
        out_ready_a[u] = 1'b1;
        @(posedge clk); #1;
        check_bit({name, " out_valid after accept"}, out_valid_a[u], 1'b0);
        check_bit({name, " in_ready after accept"}, in_ready_a[u], 1'b1);
        out_ready_a[u] = 1'b0;
    endtask

    task automatic watch_no_valid(input int u, input string name);
        int rises;
        rises = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid_a[u] === 1'b1) rises++;
        end
        check_vec({name, " out_valid cycles"}, 128'(rises), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst_a[u] = 1'b1;
            flush_a[u] = 1'b0;
            in_valid_a[u] = 1'b0;
            in_state_a[u] = '0;
            out_ready_a[u] = 1'b0;
        end
        build_sbox();

        vecs[0] = '{0, APPB_IN, APPB_OUT, 0, 1'b0};
        vecs[1] = '{0, 128'h0, ZERO_OUT, 10, 1'b0};
        vecs[2] = '{1, 128'h0, ZERO_OUT, 0, 1'b0};
        vecs[3] = '{2, 128'h0, ZERO_OUT, 0, 1'b0};
        vecs[4] = '{1, APPB_IN, APPB_OUT, 3, 1'b0};
        vecs[5] = '{2, APPB_IN, APPB_OUT, 0, 1'b1};
        vecs[6] = '{0, {128{1'b1}}, ONES_OUT, 0, 1'b1};
        vecs[7] = '{1, 128'h000102030405060708090a0b0c0d0e0f,
                    ref_model(128'h000102030405060708090a0b0c0d0e0f), 2, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) rst_a[u] = 1'b0;
        for (int u = 0; u < 3; u++) begin
            check_bit($sformatf("reset u%0d in_ready", u), in_ready_a[u], 1'b1);
            check_bit($sformatf("reset u%0d out_valid", u), out_valid_a[u], 1'b0);
            check_vec($sformatf("reset u%0d out_state", u), out_state_a[u], 128'h0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].unit, vecs[i].st, vecs[i].exp, vecs[i].hold, vecs[i].early, 1'b0,
                          $sformatf("vec%0d", i));
        end

        // Flush on the 2nd edge after a handshake, then flush with in_valid while idle
        in_valid_a[0] = 1'b1;
        in_state_a[0] = APPB_IN;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        @(posedge clk); #1;
        flush_a[0] = 1'b1;
        in_valid_a[0] = 1'b1;
        in_state_a[0] = {128{1'b1}};
        @(posedge clk); #1;
        check_bit("flush mid-SUB in_ready", in_ready_a[0], 1'b1);
        check_bit("flush mid-SUB out_valid", out_valid_a[0], 1'b0);
        @(posedge clk); #1;
        flush_a[0] = 1'b0;
        in_valid_a[0] = 1'b0;
        check_bit("flush in IDLE ignores in_valid", in_ready_a[0], 1'b1);
        watch_no_valid(0, "after flush");
        checkOutput(0, "flush keeps last", ONES_OUT);
        applyStimulus(0, 128'h0, ZERO_OUT, 0, 1'b0, 1'b0, "post-flush zero");

        // Reset during SUB
        in_valid_a[0] = 1'b1;
        in_state_a[0] = APPB_IN;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        @(posedge clk); #1;
        rst_a[0] = 1'b1;
        @(posedge clk); #1;
        rst_a[0] = 1'b0;
        check_bit("rst mid-SUB out_valid", out_valid_a[0], 1'b0);
        check_vec("rst mid-SUB out_state", out_state_a[0], 128'h0);
        check_bit("rst mid-SUB in_ready", in_ready_a[0], 1'b1);
        watch_no_valid(0, "after rst mid-SUB");

        // Reset while DONE waits on backpressure
        in_valid_a[2] = 1'b1;
        in_state_a[2] = APPB_IN;
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        @(posedge clk); #1;
        check_bit("u2 DONE before rst", out_valid_a[2], 1'b1);
        rst_a[2] = 1'b1;
        @(posedge clk); #1;
        rst_a[2] = 1'b0;
        check_bit("rst in DONE out_valid", out_valid_a[2], 1'b0);
        check_vec("rst in DONE out_state", out_state_a[2], 128'h0);
        check_bit("rst in DONE in_ready", in_ready_a[2], 1'b1);

        applyStimulus(0, APPB_IN, APPB_OUT, 2, 1'b0, 1'b1, "toggle during SUB");

        for (int i = 0; i < 30; i++) begin
            int           u;
            logic [127:0] st;
            u  = int'($urandom_range(0, 2));
            st = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(u, st, ref_model(st), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $sformatf("rand%0d u%0d", i, u));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
